// File: rtl/router_fsm.sv
// Input-side control FSM for the 1x3 router: decodes the header address,
// sequences router_register strobes, drives the FIFO write enable and source busy.
module router_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] d_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_addr;
  logic [1:0]  w_hdr_addr;
  logic [1:0]  w_sel_addr;
  logic        w_hdr_ok;
  logic        w_sel_empty;
  logic        w_soft_rst;
  logic        w_unused_d;

  assign w_hdr_addr = d_in[1:0];
  assign w_hdr_ok   = (w_hdr_addr != 2'd3);
  assign w_unused_d = ^d_in[DATA_W-1:2];

  // While decoding, the header on d_in selects the port; afterwards the latched address does.
  assign w_sel_addr = (r_state == DECODE_ADDRESS) ? w_hdr_addr : r_addr;

  always_comb begin
    w_sel_empty = 1'b0;
    w_soft_rst  = 1'b0;
    case (w_sel_addr)
      2'd0: begin w_sel_empty = fifo_empty_0; w_soft_rst = soft_reset_0; end
      2'd1: begin w_sel_empty = fifo_empty_1; w_soft_rst = soft_reset_1; end
      2'd2: begin w_sel_empty = fifo_empty_2; w_soft_rst = soft_reset_2; end
      default: begin w_sel_empty = 1'b0; w_soft_rst = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && pkt_valid && w_hdr_ok)
        r_addr <= w_hdr_addr;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state != DECODE_ADDRESS && w_soft_rst) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (pkt_valid && w_hdr_ok)
            w_next = w_sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA: w_next = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       w_next = FIFO_FULL_STATE;
          else if (!pkt_valid) w_next = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) w_next = LOAD_AFTER_FULL;
        // Parity may already be in the register if the FIFO filled on the parity byte.
        LOAD_AFTER_FULL:
          if (parity_done)        w_next = DECODE_ADDRESS;
          else if (low_pkt_valid) w_next = LOAD_PARITY;
          else                    w_next = LOAD_DATA;
        LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (w_sel_empty) w_next = LOAD_FIRST_DATA;
        default: w_next = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                    (r_state == LOAD_AFTER_FULL);
    busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, async reset sequence, and
// randomized traffic checked against a rule-level reference model.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       fifo_full = 1'b0;
  logic [2:0] emp = 3'b111;
  logic [2:0] sr  = 3'b000;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  router_fsm #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .d_in(d_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  wire [7:0] w_out = {detect_add, lfd_state, ld_state, laf_state,
                      full_state, rst_int_reg, write_enb_reg, busy};

  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0010;
  localparam logic [7:0] O_LAF  = 8'b0001_0011;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LP   = 8'b0000_0011;
  localparam logic [7:0] O_CHK  = 8'b0000_0101;
  localparam logic [7:0] O_WAIT = 8'b0000_0001;

  typedef struct {
    logic       pv;
    logic [7:0] d;
    logic       ff;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pv, input logic [7:0] d, input logic ff,
                     input logic [2:0] e, input logic [2:0] s, input logic pd,
                     input logic lpv, input logic [7:0] exp, input string name);
    vec_t v;
    v.pv = pv; v.d = d; v.ff = ff; v.emp = e; v.sr = s;
    v.pd = pd; v.lpv = lpv; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the packet protocol expressed as phases of a packet.
  localparam int P_IDLE = 0, P_FIRST = 1, P_BODY = 2, P_PAR = 3,
                 P_STALL = 4, P_RESUME = 5, P_WAIT = 6, P_CHK = 7;
  int         m_phase;
  logic [1:0] m_port;
  logic [7:0] m_out_of[8];

  function automatic int model_next(input int ph, input logic [1:0] port,
                                    input logic pv, input logic [7:0] d,
                                    input logic ff, input logic [2:0] e,
                                    input logic [2:0] s, input logic pd,
                                    input logic lpv);
    int hdr;
    hdr = int'(d[1:0]);
    if (ph != P_IDLE && s[port]) return P_IDLE;
    if (ph == P_IDLE) begin
      if (!pv || hdr == 3) return P_IDLE;
      return e[hdr] ? P_FIRST : P_WAIT;
    end
    if (ph == P_FIRST) return P_BODY;
    if (ph == P_BODY)  return ff ? P_STALL : (pv ? P_BODY : P_PAR);
    if (ph == P_STALL) return ff ? P_STALL : P_RESUME;
    if (ph == P_RESUME) return pd ? P_IDLE : (lpv ? P_PAR : P_BODY);
    if (ph == P_PAR)   return P_CHK;
    if (ph == P_CHK)   return ff ? P_STALL : P_IDLE;
    return e[port] ? P_FIRST : P_WAIT;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pkt_valid = 1'b0; fifo_full = 1'b0; sr = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0; emp = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    m_phase = P_IDLE;
    m_port  = 2'd0;
  endtask

  initial begin
    m_out_of[P_IDLE] = O_DEC;  m_out_of[P_FIRST]  = O_LFD;
    m_out_of[P_BODY] = O_LD;   m_out_of[P_PAR]    = O_LP;
    m_out_of[P_STALL] = O_FULL; m_out_of[P_RESUME] = O_LAF;
    m_out_of[P_WAIT] = O_WAIT; m_out_of[P_CHK]    = O_CHK;

    // Normal packet to port 1: 8 payload bytes then parity
    add(1, 8'h15, 0, 3'b111, 3'b000, 0, 0, O_LFD, "norm_hdr");
    for (int i = 0; i < 8; i++) add(1, 8'(i + 1), 0, 3'b111, 3'b000, 0, 0, O_LD, "norm_ld");
    add(0, 8'hA5, 0, 3'b111, 3'b000, 0, 0, O_LP, "norm_par");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_CHK, "norm_chk");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_DEC, "norm_done");
    // Busy destination port 2
    add(1, 8'h16, 0, 3'b011, 3'b000, 0, 0, O_WAIT, "wait_hdr");
    for (int i = 0; i < 5; i++) add(1, 8'h16, 0, 3'b011, 3'b000, 0, 0, O_WAIT, "wait_hold");
    add(1, 8'h16, 0, 3'b111, 3'b000, 0, 0, O_LFD, "wait_lfd");
    add(1, 8'h01, 0, 3'b111, 3'b000, 0, 0, O_LD, "wait_ld");
    add(0, 8'h55, 0, 3'b111, 3'b000, 0, 0, O_LP, "wait_par");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_CHK, "wait_chk");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_DEC, "wait_done");
    // Full stall after byte 3 for 4 cycles
    add(1, 8'h14, 0, 3'b111, 3'b000, 0, 0, O_LFD, "stall_hdr");
    add(1, 8'h01, 0, 3'b111, 3'b000, 0, 0, O_LD, "stall_b1");
    add(1, 8'h02, 0, 3'b111, 3'b000, 0, 0, O_LD, "stall_b2");
    add(1, 8'h03, 0, 3'b111, 3'b000, 0, 0, O_LD, "stall_b3");
    for (int i = 0; i < 4; i++) add(1, 8'h04, 1, 3'b111, 3'b000, 0, 0, O_FULL, "stall_full");
    add(1, 8'h04, 0, 3'b111, 3'b000, 0, 0, O_LAF, "stall_laf");
    add(1, 8'h04, 0, 3'b111, 3'b000, 0, 0, O_LD, "stall_resume");
    add(0, 8'h77, 0, 3'b111, 3'b000, 0, 0, O_LP, "stall_par");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_CHK, "stall_chk");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_DEC, "stall_done");
    // Full exactly on the parity byte
    add(1, 8'h02, 0, 3'b111, 3'b000, 0, 0, O_LFD, "fpar_hdr");
    add(1, 8'h01, 0, 3'b111, 3'b000, 0, 0, O_LD, "fpar_ld");
    add(0, 8'h33, 1, 3'b111, 3'b000, 0, 1, O_FULL, "fpar_full");
    add(0, 8'h33, 1, 3'b111, 3'b000, 0, 1, O_FULL, "fpar_hold");
    add(0, 8'h33, 0, 3'b111, 3'b000, 0, 1, O_LAF, "fpar_laf");
    add(0, 8'h33, 0, 3'b111, 3'b000, 0, 1, O_LP, "fpar_lp");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_CHK, "fpar_chk");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_DEC, "fpar_done");
    // Invalid address is dropped
    add(1, 8'h13, 0, 3'b111, 3'b000, 0, 0, O_DEC, "bad_addr");
    add(0, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_DEC, "bad_idle");
    // Soft reset: other port ignored, own port aborts
    add(1, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_LFD, "sr_hdr");
    add(1, 8'h01, 0, 3'b111, 3'b100, 0, 0, O_LD, "sr_lfd_other");
    add(1, 8'h02, 0, 3'b111, 3'b100, 0, 0, O_LD, "sr_other");
    add(1, 8'h03, 0, 3'b111, 3'b001, 0, 0, O_DEC, "sr_own");
    // Soft reset beats fifo_full
    add(1, 8'h01, 0, 3'b111, 3'b000, 0, 0, O_LFD, "srf_hdr");
    add(1, 8'h01, 0, 3'b111, 3'b000, 0, 0, O_LD, "srf_ld");
    add(1, 8'h02, 1, 3'b111, 3'b010, 0, 0, O_DEC, "srf_abort");
    // parity_done exit from LOAD_AFTER_FULL, and CHECK with full
    add(1, 8'h00, 0, 3'b111, 3'b000, 0, 0, O_LFD, "pd_hdr");
    add(1, 8'h01, 0, 3'b111, 3'b000, 0, 0, O_LD, "pd_ld");
    add(0, 8'h09, 0, 3'b111, 3'b000, 0, 0, O_LP, "pd_lp");
    add(0, 8'h00, 1, 3'b111, 3'b000, 0, 0, O_CHK, "pd_chk");
    add(0, 8'h00, 1, 3'b111, 3'b000, 0, 0, O_FULL, "pd_chk_full");
    add(0, 8'h00, 0, 3'b111, 3'b000, 1, 0, O_LAF, "pd_laf");
    add(0, 8'h00, 0, 3'b111, 3'b000, 1, 0, O_DEC, "pd_exit");

    rst = 1'b0;
    #23;
    check("reset_out", w_out, O_DEC);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      pkt_valid = vecs[i].pv; d_in = vecs[i].d; fifo_full = vecs[i].ff;
      emp = vecs[i].emp; sr = vecs[i].sr; parity_done = vecs[i].pd;
      low_pkt_valid = vecs[i].lpv;
      @(posedge clk);
      #1;
      check(vecs[i].name, w_out, vecs[i].exp);
    end

    // Asynchronous reset in the middle of LOAD_DATA
    @(negedge clk);
    pkt_valid = 1'b1; d_in = 8'h15; fifo_full = 1'b0; emp = 3'b111; sr = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    @(posedge clk); #1 check("ar_lfd", w_out, O_LFD);
    @(negedge clk); d_in = 8'h01;
    @(posedge clk); #1 check("ar_ld", w_out, O_LD);
    #2 rst = 1'b0;
    #1 check("ar_async", w_out, O_DEC);
    #7 check("ar_held", w_out, O_DEC);
    #2 rst = 1'b1;
    @(negedge clk); pkt_valid = 1'b0;
    @(posedge clk); #1 check("ar_after", w_out, O_DEC);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      d_in          = 8'($urandom);
      fifo_full     = ($urandom_range(0, 4) == 0);
      emp           = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 9) < 7)};
      sr            = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 29) == 0)};
      parity_done   = ($urandom_range(0, 2) == 0);
      low_pkt_valid = $urandom_range(0, 1) == 1;
      @(posedge clk);
      if (m_phase == P_IDLE && pkt_valid && d_in[1:0] != 2'd3) begin
        m_phase = model_next(m_phase, m_port, pkt_valid, d_in, fifo_full, emp,
                             sr, parity_done, low_pkt_valid);
        m_port  = d_in[1:0];
      end else begin
        m_phase = model_next(m_phase, m_port, pkt_valid, d_in, fifo_full, emp,
                             sr, parity_done, low_pkt_valid);
      end
      #1;
      check("random", w_out, m_out_of[m_phase]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
